// File: rtl/stream_mux_arb_pkg.sv
// Shared definitions for the stream_mux_arb block: selection-mode encodings.
package stream_mux_arb_pkg;

    // Value of the mode input selecting each grant policy.
    localparam logic MODE_FORCED = 1'b0;
    localparam logic MODE_RR     = 1'b1;

endpackage : stream_mux_arb_pkg

// File: rtl/stream_mux_arb_rr_arbiter.sv
// Round-robin arbiter: grants the first requester found at or after ptr,
// wrapping modulo NCH. Purely combinational; the pointer lives in the caller.
module stream_mux_arb_rr_arbiter #(
    parameter  int NCH  = 4,
    localparam int SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [NCH-1:0]  grant,
    output logic [SELW-1:0] idx,
    output logic            found
);

    int pos;

    // Rotating priority search starting at ptr; first hit wins.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // it unassigned, which would otherwise infer a latch.
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int i = 0; i < NCH; i++) begin
            pos = int'(ptr) + i;
            if (pos >= NCH) begin
                pos = pos - NCH;
            end
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = pos[SELW-1:0];
            end
        end
    end

endmodule : stream_mux_arb_rr_arbiter

// File: rtl/stream_mux_arb.sv
// N-channel valid/ready stream multiplexer with a registered output stage.
// Channel selection is either forced by sel or round-robin across requesters.
module stream_mux_arb
    import stream_mux_arb_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int NCH   = 4,
    localparam int SELW  = $clog2(NCH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]     in_valid,
    output logic [NCH-1:0]     in_ready,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_ch,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_ch_q,   out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  rr_ptr_q,   rr_ptr_d;

    logic [NCH-1:0]   arb_grant;
    logic [SELW-1:0]  arb_idx;
    logic             arb_found;

    logic             sel_in_range;
    logic             forced_any;
    logic [NCH-1:0]   grant_vec;
    logic [SELW-1:0]  grant_idx;
    logic             grant_any;
    logic             load_en;
    logic             xfer;

    stream_mux_arb_rr_arbiter #(.NCH(NCH)) u_rr_arbiter (
        .req   (in_valid),
        .ptr   (rr_ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .found (arb_found)
    );

    // When NCH is a power of two every sel encoding names a real channel.
    if ((1 << SELW) == NCH) begin : g_sel_full
        assign sel_in_range = 1'b1;
    end else begin : g_sel_partial
        assign sel_in_range = (int'(sel) < NCH);
    end

    assign forced_any = sel_in_range && in_valid[sel];
    assign load_en    = !out_valid_q || out_ready;

    // Pick the grant source for the current mode; data never feeds this path.
    always_comb begin
        if (mode == MODE_RR) begin
            grant_vec = arb_grant;
            grant_idx = arb_idx;
            grant_any = arb_found;
        end else begin
            grant_vec = forced_any ? (NCH'(1) << sel) : '0;
            grant_idx = sel;
            grant_any = forced_any;
        end
    end

    assign in_ready = load_en ? grant_vec : '0;
    assign xfer     = load_en && grant_any;

    // Output register and round-robin pointer next-state.
    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            out_data_d  = in_data[int'(grant_idx)*WIDTH +: WIDTH];
            out_ch_d    = grant_idx;
            out_valid_d = 1'b1;
            if (mode == MODE_RR) begin
                rr_ptr_d = (grant_idx == SELW'(NCH - 1)) ? '0 : grant_idx + SELW'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset drops any held word and rewinds the pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge
            // values regardless of statement order.
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule : stream_mux_arb

// File: tb/tb_stream_mux_arb.sv
// Directed bench for stream_mux_arb with WIDTH=4, NCH=4.
module tb_stream_mux_arb;

    localparam int WIDTH = 4;
    localparam int NCH   = 4;
    localparam int SELW  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_ch;
    logic                 out_valid;
    logic                 out_ready;

    int total = 0;
    int bad   = 0;

    stream_mux_arb #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 1 ns past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [3:0] d, input logic [1:0] c);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".data"},  32'(out_data),  32'(d));
        check({tag, ".ch"},    32'(out_ch),    32'(c));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = '0;
        mode      = 1'b0;
        sel       = '0;
        out_ready = 1'b0;
        #2;
        check_out("reset", 1'b0, 4'h0, 2'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Forced select of channel 2.
        mode      = 1'b0;
        sel       = 2'd2;
        in_data   = {4'h8, 4'hA, 4'h6, 4'h5};
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        check("forced.rdy0", 32'(in_ready), 32'h4);
        tick();
        check_out("forced.w0", 1'b1, 4'hA, 2'd2);
        check("forced.rdy1", 32'(in_ready), 32'h4);
        tick();
        check_out("forced.w1", 1'b1, 4'hA, 2'd2);

        // Round-robin over all channels, data k+5; pointer still 0.
        mode    = 1'b1;
        in_data = {4'h8, 4'h7, 4'h6, 4'h5};
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("rr.rdy%0d", i), 32'(in_ready), 32'(1 << (i % 4)));
            tick();
            check_out($sformatf("rr.w%0d", i), 1'b1, 4'((i % 4) + 5), 2'(i % 4));
        end

        // Pointer is 1: a lone ch1 request moves it to 2.
        in_valid = 4'b0010;
        #1;
        check("sparse.rdy_a", 32'(in_ready), 32'h2);
        tick();
        check_out("sparse.a", 1'b1, 4'h6, 2'd1);

        // Pointer 2 with ch3 and ch1 requesting: ch3 first, then wrap to ch1.
        in_valid = 4'b1010;
        #1;
        check("sparse.rdy_b", 32'(in_ready), 32'h8);
        tick();
        check_out("sparse.b", 1'b1, 4'h8, 2'd3);
        in_data = {4'h8, 4'hC, 4'h7, 4'h5};
        #1;
        check("sparse.rdy_c", 32'(in_ready), 32'h2);
        tick();
        check_out("sparse.c", 1'b1, 4'h7, 2'd1);

        // Pointer should now be 2: with everyone valid, ch2 is offered.
        in_valid = 4'b1111;
        #1;
        check("sparse.ptr2", 32'(in_ready), 32'h4);

        // Backpressure for 5 cycles holds 4'h7 from ch1.
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp.rdy%0d", i), 32'(in_ready), 32'h0);
            tick();
            check_out($sformatf("bp.hold%0d", i), 1'b1, 4'h7, 2'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp.release_rdy", 32'(in_ready), 32'h4);
        tick();
        check_out("bp.release", 1'b1, 4'hC, 2'd2);

        // Forced sel=3 with ch3 idle: no grant, held word drains.
        mode     = 1'b0;
        sel      = 2'd3;
        in_valid = 4'b0111;
        #1;
        check("idle.forced_rdy", 32'(in_ready), 32'h0);
        tick();
        check_out("idle.drain", 1'b0, 4'hC, 2'd2);
        mode     = 1'b1;
        in_valid = 4'b0000;
        #1;
        check("idle.rr_rdy", 32'(in_ready), 32'h0);
        tick();
        check_out("idle.empty", 1'b0, 4'hC, 2'd2);

        // Pointer kept at 3 through mode 0: grants ch3 then ch0.
        in_valid = 4'b1111;
        tick();
        check_out("rst.pre_a", 1'b1, 4'h8, 2'd3);
        tick();
        check_out("rst.pre_b", 1'b1, 4'h5, 2'd0);

        // Pointer is now 1; asynchronous reset mid-stream drops the word.
        rst_n = 1'b0;
        #1;
        check_out("rst.async", 1'b0, 4'h0, 2'd0);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst.rdy_after", 32'(in_ready), 32'h1);
        tick();
        check_out("rst.first", 1'b1, 4'h5, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_stream_mux_arb

// File: doc/stream_mux_arb.md
Name: stream_mux_arb

Overview:
- Parametrised N-channel, W-bit stream multiplexer; successor to the team's fixed 4-bit 2:1 mux.
- Adds a valid/ready handshake on every input and on the output, and a registered output stage.
- Selection is either forced (`sel` input) or round-robin arbitration across requesting channels.
- Sits between multiple data producers and a single shared downstream consumer.

Parameters:
- WIDTH, 4, data bits per channel.
- NCH, 4, number of input channels (2..16).
- SELW, $clog2(NCH) (localparam, derived), width of the channel index.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel valid.
- in_ready  output  NCH  per-channel ready (combinational).
- mode  input  1  0 = forced select, 1 = round-robin.
- sel  input  SELW  channel index used when mode=0.
- out_data  output  WIDTH  registered data.
- out_ch  output  SELW  index of the channel that supplied out_data.
- out_valid  output  1  registered valid.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer rr_ptr=0.
- load_en = !out_valid || out_ready. The output register accepts a new word only when load_en=1.
- Grant logic (combinational):
  - mode=0: grant channel sel if in_valid[sel]=1. If sel>=NCH, no grant.
  - mode=1: grant the first requesting channel found searching rr_ptr, rr_ptr+1, ... modulo NCH. If no channel is valid, no grant.
- in_ready[k] = load_en && grant==k. At most one in_ready bit is high per cycle.
- Transfer on channel g (in_valid[g] && in_ready[g]) at clock edge:
  - out_data<=in_data[g], out_ch<=g, out_valid<=1.
  - If mode=1, rr_ptr<=(g+1) mod NCH.
  - If mode=0, rr_ptr is unchanged.
- No transfer and out_ready=1: out_valid<=0. out_data and out_ch hold their last values.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_ch and out_valid are stable. All in_ready bits are 0.
- Latency and throughput:
  - One cycle from input transfer to out_valid.
  - Full throughput: one word per cycle while out_ready=1 and some granted channel is valid.
- Combinational paths: in_ready depends on out_ready, in_valid, mode and sel. There is no path from in_data to in_ready.
- Mode or sel change:
  - Takes effect on the next grant evaluation.
  - Never modifies a word already held in the output register.
  - rr_ptr is retained across mode=0 periods.
- Wrap-around: a grant on channel NCH-1 in mode=1 sets rr_ptr=0.
- Fairness: in mode=1 with all channels continuously valid and out_ready=1, grants cycle 0,1,...,NCH-1,0,... with no channel starved.
- Reset mid-operation: output and pointer return to reset values immediately. A held word is dropped.
- Input-side rule: producers must hold in_data stable while in_valid=1 and in_ready=0. The block does not check this.

Decomposition:
- Shared package holds:
  - mode encodings MODE_FORCED=1'b0, MODE_RR=1'b1;
  - a clog2 helper function, if the toolchain lacks $clog2.
- One natural sub-module: rr_arbiter. It is parametrised by NCH and has:
  - inputs: request vector and rr_ptr;
  - outputs: one-hot grant and encoded index.
- The output register and handshake logic stay in the top module.

Test Plan (WIDTH=4, NCH=4):
- Reset check: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0 and out_ch=0 immediately. After release, the first mode=1 grant goes to channel 0.
- Forced select: mode=0, sel=2, in_data ch2=4'hA, all in_valid=1, out_ready=1 -> next cycle out_data=4'hA, out_ch=2. in_ready is 4'b0100 each cycle.
- Round-robin: mode=1, all valid, data ch k = k+5, out_ready=1 -> out_ch sequence 0,1,2,3,0 and out_data 5,6,7,8,5 on consecutive cycles.
- Sparse requests and wrap: mode=1, only ch3 and ch1 valid, rr_ptr=2 -> grant ch3 then ch1. rr_ptr ends at 2.
- Backpressure: out_valid=1 holding 4'h7 from ch1, out_ready=0 for 5 cycles -> out_data=4'h7 and out_ch=1 stable, in_ready=0. On out_ready=1, the next word loads in the same edge.
- Invalid sel and idle: mode=0, sel=3 with ch3 invalid, then mode=1 with no valids -> no in_ready asserted. out_valid drops to 0 after the held word is consumed.
